// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: shadow config store that shifts and loads the daisy-chained GPIO pad control blocks
module gpio_serial_loader #(
    parameter int NUM_IO = 38,
    parameter int CFG_W = 13,
    parameter int DIV = 4,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = 13'h1803
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_wdata,
    output logic [CFG_W-1:0] cfg_rdata,
    input  logic             xfer_start,
    output logic             busy,
    output logic             done,
    output logic             serial_clock,
    output logic             serial_data,
    output logic             serial_load
);
    localparam int AW = NUM_IO > 1 ? $clog2(NUM_IO) : 1;
    localparam int BW = CFG_W > 1 ? $clog2(CFG_W) : 1;
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD} state_t;

    state_t state, state_n;
    logic [AW-1:0] pad, pad_n;
    logic [BW-1:0] bit_idx, bit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CFG_W-1:0] shadow [NUM_IO];
    logic [CFG_W-1:0] word;
    logic addr_ok, wr_en, last_phase;

    assign addr_ok = {1'b0, cfg_addr} < 7'(NUM_IO);
    assign wr_en = cfg_we && state == IDLE && addr_ok;
    assign cfg_rdata = addr_ok ? shadow[cfg_addr[AW-1:0]] : '0;
    assign last_phase = cnt == CW'(DIV - 1);
    // a write landing in the start cycle must already be visible in the first shifted bit
    assign word = (wr_en && cfg_addr[AW-1:0] == pad_n) ? cfg_wdata : shadow[pad_n];

    genvar g;
    for (g = 0; g < NUM_IO; g++) begin : g_shadow
        // one shadow word per pad, writable only while the chain is idle
        always_ff @(posedge wb_clk_i or posedge wb_rst_i)
            if (wb_rst_i) shadow[g] <= DEFAULT_CFG;
            else if (wr_en && cfg_addr[AW-1:0] == AW'(g)) shadow[g] <= cfg_wdata;
    end

    // next state: each phase lasts DIV cycles; the bit pointer walks pad NUM_IO-1 MSB down to pad 0 bit 0
    always_comb begin
        state_n = state;
        pad_n = pad;
        bit_n = bit_idx;
        cnt_n = last_phase ? '0 : cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (xfer_start) begin
                    state_n = SHIFT_LO;
                    pad_n = AW'(NUM_IO - 1);
                    bit_n = BW'(CFG_W - 1);
                end
            end
            SHIFT_LO: if (last_phase) state_n = SHIFT_HI;
            SHIFT_HI: if (last_phase) begin
                if (pad == '0 && bit_idx == '0) state_n = LOAD_SETUP;
                else begin
                    state_n = SHIFT_LO;
                    bit_n = bit_idx == '0 ? BW'(CFG_W - 1) : bit_idx - 1'b1;
                    pad_n = bit_idx == '0 ? pad - 1'b1 : pad;
                end
            end
            LOAD_SETUP: if (last_phase) state_n = LOAD;
            LOAD: if (last_phase) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register; outputs are registered from the next state so they line up with it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state <= IDLE;
            pad <= '0;
            bit_idx <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            serial_clock <= 1'b0;
            serial_data <= 1'b0;
            serial_load <= 1'b0;
        end else begin
            state <= state_n;
            pad <= pad_n;
            bit_idx <= bit_n;
            cnt <= cnt_n;
            busy <= state_n != IDLE;
            done <= state == LOAD && state_n == IDLE;
            serial_clock <= state_n == SHIFT_HI;
            serial_data <= (state_n == SHIFT_LO || state_n == SHIFT_HI) && word[bit_n];
            serial_load <= state_n == LOAD;
        end
endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: scoreboard bench for the default chain and a small 2x3 chain
module tb_gpio_serial_loader;
    localparam int N = 38 * 13;
    localparam int LEN = 2 * 4 * (N + 1);

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic we = 0, start = 0, busy, done, sc, sd, sl;
    logic [5:0] addr = 0;
    logic [12:0] wdata = 0, rdata;
    logic s_we = 0, s_start = 0, s_busy, s_done, s_sc, s_sd, s_sl;
    logic [5:0] s_addr = 0;
    logic [2:0] s_wdata = 0, s_rdata;

    gpio_serial_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata),
        .cfg_rdata(rdata), .xfer_start(start), .busy(busy), .done(done),
        .serial_clock(sc), .serial_data(sd), .serial_load(sl)
    );

    gpio_serial_loader #(.NUM_IO(2), .CFG_W(3), .DIV(1), .DEFAULT_CFG(3'b000)) dut_s (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(s_we), .cfg_addr(s_addr), .cfg_wdata(s_wdata),
        .cfg_rdata(s_rdata), .xfer_start(s_start), .busy(s_busy), .done(s_done),
        .serial_clock(s_sc), .serial_data(s_sd), .serial_load(s_sl)
    );

    int checks = 0, errors = 0;
    logic [N-1:0] exp_img_q[$];
    int exp_len_q[$];
    logic exp_bit_q[$];
    int s_len_q[$];
    logic [12:0] model [38];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic [N-1:0] chain = '0;
    logic prev_sc = 0, prev_sl = 0, prev_done = 0, prev_sd = 0, sd_rise = 0;
    int edges = 0, hi_len = 0, ld_len = 0, busy_len = 0, loads = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_img_q.delete();
            exp_len_q.delete();
            edges = 0; hi_len = 0; ld_len = 0; busy_len = 0;
            prev_sc = 0; prev_sl = 0; prev_done = 0; prev_sd = 0;
        end else begin
            if (sc && !prev_sc) begin
                chain = {chain[N-2:0], sd};
                edges++;
                sd_rise = sd;
            end
            if (!sc && prev_sc) begin
                check("clk_high_len", hi_len, 4);
                check("data_stable_high", prev_sd, sd_rise);
            end
            hi_len = sc ? hi_len + 1 : 0;
            if (sl) ld_len++;
            if (!sl && prev_sl) begin
                loads++;
                check("load_len", ld_len, 4);
                check("edge_count", edges, N);
                checks++;
                if (exp_img_q.size() == 0) begin
                    errors++;
                    $display("FAIL chain_image unexpected load pulse");
                end else begin
                    logic [N-1:0] e;
                    e = exp_img_q.pop_front();
                    if (chain !== e) begin
                        errors++;
                        $display("FAIL chain_image actual=%0h required=%0h", chain, e);
                    end
                end
                ld_len = 0;
            end
            if (busy) busy_len++;
            if (done) begin
                check("done_busy_low", busy, 0);
                check("done_single", prev_done, 0);
                if (exp_len_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL busy_len unexpected done actual=%0d", busy_len);
                end else check("busy_len", busy_len, exp_len_q.pop_front());
                busy_len = 0;
                edges = 0;
            end
            prev_sc = sc; prev_sl = sl; prev_done = done; prev_sd = sd;
        end
    end

    logic s_prev_sc = 0, s_prev_sl = 0;
    int s_lo = 0, s_ld = 0, s_blen = 0, s_loads = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_bit_q.delete();
            s_len_q.delete();
            s_prev_sc = 0; s_prev_sl = 0; s_lo = 0; s_ld = 0; s_blen = 0;
        end else begin
            if (s_sc && !s_prev_sc) begin
                if (exp_bit_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL small_bit unexpected edge actual=%0b", s_sd);
                end else check("small_bit", s_sd, exp_bit_q.pop_front());
            end
            if (s_sl && !s_prev_sl) check("small_setup_low", s_lo, 1);
            s_lo = s_sc ? 0 : s_lo + 1;
            if (s_sl) s_ld++;
            if (!s_sl && s_prev_sl) begin
                s_loads++;
                check("small_load_len", s_ld, 1);
                s_ld = 0;
            end
            if (s_busy) s_blen++;
            if (s_done) begin
                if (s_len_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL small_busy_len unexpected done actual=%0d", s_blen);
                end else check("small_busy_len", s_blen, s_len_q.pop_front());
                s_blen = 0;
            end
            s_prev_sc = s_sc; s_prev_sl = s_sl;
        end
    end

    task automatic reset_model();
        for (int p = 0; p < 38; p++) model[p] = 13'h1803;
    endtask

    task automatic rd(input int a, input logic [12:0] req, input string name);
        addr = 6'(a);
        #1 check(name, rdata, req);
    endtask

    task automatic wr(input int a, input logic [12:0] d);
        @(posedge clk); #1;
        we = 1; addr = 6'(a); wdata = d;
        @(posedge clk); #1;
        we = 0;
    endtask

    task automatic push_expect();
        logic [N-1:0] img;
        for (int p = 0; p < 38; p++) img[p*13 +: 13] = model[p];
        exp_img_q.push_back(img);
        exp_len_q.push_back(LEN);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout actual=busy%0b required=done", name, busy);
        end
    endtask

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sclk", sc, 0);
        check("rst_sdata", sd, 0);
        check("rst_sload", sl, 0);
        rd(0, 13'h1803, "rst_rd0");
        rd(37, 13'h1803, "rst_rd37");
        rd(40, 13'h0000, "rst_rd40");

        @(posedge clk); #1;
        s_we = 1; s_addr = 1; s_wdata = 3'b101;
        @(posedge clk); #1;
        s_addr = 0; s_wdata = 3'b011;
        @(posedge clk); #1;
        s_we = 0;
        foreach (exp_bit_q[i]) ;
        exp_bit_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        s_len_q.push_back(14);
        s_start = 1;
        @(posedge clk); #1 s_start = 0;
        repeat (30) @(posedge clk);
        #1 check("small_loads", s_loads, 1);
        check("small_bits_left", exp_bit_q.size(), 0);

        push_expect();
        pulse_start();
        wait_done("default_xfer");
        repeat (3) @(posedge clk);
        #1 check("loads_after_1", loads, 1);

        push_expect();
        pulse_start();
        repeat (200) @(posedge clk);
        #1 we = 1; addr = 5; wdata = 13'h0001; start = 1;
        @(posedge clk); #1 we = 0; start = 0;
        wait_done("busy_ignore_xfer");
        repeat (10) @(posedge clk);
        #1 check("no_requeue_busy", busy, 0);
        check("loads_after_2", loads, 2);
        rd(5, 13'h1803, "busy_write_ignored");

        @(posedge clk); #1;
        we = 1; addr = 37; wdata = 13'h1FFF; start = 1;
        model[37] = 13'h1FFF;
        push_expect();
        @(posedge clk); #1 we = 0; start = 0;
        wait_done("same_cycle_xfer");
        repeat (3) @(posedge clk);
        #1 check("loads_after_3", loads, 3);
        rd(37, 13'h1FFF, "same_cycle_rd37");

        push_expect();
        pulse_start();
        begin
            int n = 0;
            while (edges < 100 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("reach_100_edges", edges >= 100, 1);
        end
        rst = 1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sclk", sc, 0);
        check("midrst_sdata", sd, 0);
        check("midrst_sload", sl, 0);
        @(posedge clk); #1 rst = 0;
        reset_model();
        rd(37, 13'h1803, "midrst_rd37");
        repeat (20) @(posedge clk);
        #1 check("midrst_no_load", loads, 3);
        push_expect();
        pulse_start();
        wait_done("after_reset_xfer");
        repeat (3) @(posedge clk);
        #1 check("loads_after_4", loads, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
- Management-side controller that holds a shadow configuration word for every user GPIO pad.
- On request, it sequences the daisy-chained per-pad GPIO control blocks through serial_clock / serial_data / serial_load.
- It sits between the management core register bus and the GPIO control chain. Firmware programs pad modes, such as the mgmt GPIO and the SPI/UART pins, and applies them with one start strobe.

Parameters:
- NUM_IO, 38: number of pads in the chain.
- CFG_W, 13: configuration bits per pad.
- DIV, 4: serial_clock half-period in wb_clk_i cycles; must be >= 1.
- DEFAULT_CFG, 13'h1803: reset value of every shadow word (mgmt-controlled input).

Ports:
- wb_clk_i, input, 1: sole clock.
- wb_rst_i, input, 1: reset, asynchronous, active-high.
- cfg_we, input, 1: shadow write strobe.
- cfg_addr, input, 6: pad index for read/write.
- cfg_wdata, input, CFG_W: shadow write data.
- cfg_rdata, output, CFG_W: shadow word at cfg_addr (combinational).
- xfer_start, input, 1: single-cycle request to shift and load the whole chain.
- busy, output, 1: transfer in progress.
- done, output, 1: one-cycle pulse at transfer end.
- serial_clock, output, 1: chain shift clock.
- serial_data, output, 1: chain shift data.
- serial_load, output, 1: chain load strobe.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values:
  - all shadow words = DEFAULT_CFG
  - busy = 0, done = 0
  - serial_clock = 0, serial_data = 0, serial_load = 0
  - FSM = IDLE
  - All outputs are registered, except cfg_rdata.
- Shadow access:
  - cfg_we while IDLE and cfg_addr < NUM_IO writes cfg_wdata at the clock edge.
  - Writes with cfg_addr >= NUM_IO are ignored.
  - Writes while busy are ignored.
  - cfg_rdata = shadow[cfg_addr], or 0 when cfg_addr >= NUM_IO.
- Bit order: N = NUM_IO*CFG_W bits. Pad NUM_IO-1 is shifted first, MSB first within each pad. Pad 0 bit 0 is shifted last.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD.
  - IDLE: xfer_start=1 -> SHIFT_LO; busy=1 from the next cycle; serial_data = first bit.
  - SHIFT_LO: serial_clock=0, serial_data stable, held DIV cycles -> SHIFT_HI.
  - SHIFT_HI: serial_clock=1 for DIV cycles. serial_data does not change while serial_clock is high.
    - If bits remain: advance the bit pointer and go to SHIFT_LO, presenting the new bit on entry.
    - Otherwise go to LOAD_SETUP.
  - LOAD_SETUP: serial_clock=0, serial_data=0, held DIV cycles -> LOAD.
  - LOAD: serial_load=1 for DIV cycles -> IDLE, with serial_load=0, busy=0 and done=1 for exactly one cycle.
- Latency: busy is high for exactly 2*DIV*(N+1) cycles; defaults give 3960. done coincides with the first cycle busy is low.
- Pointer implementation: pad index and bit-in-pad counters. No N-bit shift register is required.
- Boundary conditions:
  - xfer_start while busy: ignored; no queuing.
  - xfer_start in the cycle done is high: accepted as a new transfer.
  - cfg_we and xfer_start in the same IDLE cycle: the write lands first and is included in the transfer.
  - Reset mid-transfer: immediately forces the reset values. No serial_load pulse is produced. Shadow returns to DEFAULT_CFG.
  - xfer_start held high for multiple cycles: one transfer; it re-triggers only if still high in the cycle done is high.

Test Plan:
- Reset check: assert wb_rst_i for 3 cycles, release. Required: busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0; reading addr 0 and addr 37 gives 13'h1803; reading addr 40 gives 0.
- Small config, bit order: NUM_IO=2, CFG_W=3, DIV=1. Write pad1=3'b101 and pad0=3'b011, then pulse xfer_start. Required: bits sampled on the 6 serial_clock rising edges are 1,0,1,0,1,1; serial_load is high 1 cycle, after serial_clock has been low 1 cycle; busy is high 14 cycles; done pulses once.
- Default config, timing: pulse xfer_start once. Required:
  - exactly 494 serial_clock rising edges, each high phase 4 cycles
  - serial_load high 4 cycles
  - busy high 3960 cycles
  - done high 1 cycle
  - a chain model reconstructs 38×13'h1803.
- Ignored operations while busy: mid-transfer, write pad5=13'h0001 and pulse xfer_start again. Required: the write is ignored (readback still 13'h1803 after done); only one load pulse occurs; the transfer length is unchanged.
- Same-cycle write and start: cfg_we (pad37=13'h1FFF) and xfer_start in the same IDLE cycle. Required: the first 13 shifted bits are all 1.
- Reset mid-transfer: assert wb_rst_i after 100 serial_clock edges. Required: all outputs are 0 in the same cycle; serial_load never rises; shadow returns to DEFAULT_CFG; a later xfer_start completes normally.
